mc_control: RTL and testbench

Main control state machine for the multi-cycle CPU. It decodes the 6-bit opcode held in the instruction register and sequences fetch, decode, execute, memory and write-back over 2–5 cycles per instruction. It drives the datapath enables, the muxes, and the 2-bit `ALUOP` code consumed by the ALU control unit. It also keeps a retired-instruction counter for debug and performance measurement.

---
 rtl/mc_control_if.sv | 40 ++++
 rtl/mc_control.sv | 138 +++++++++++++
 tb/tb_mc_control.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mc_control_if.sv
// Controller-to-datapath bundle: opcode/zero in, datapath enables, mux selects and debug out.
// No latency of its own; the controller owns every output listed in the master modport.
// No backpressure: the datapath consumes the strobes in the cycle they are presented.
`timescale 1ns/1ps
interface mc_control_if #(parameter int CNT_W = 32);
    logic [5:0]       Op;
    logic             Zero;
    logic             PCEn;
    logic             PCWrite;
    logic             PCWriteCond;
    logic [1:0]       PCSource;
    logic             IorD;
    logic             MemRead;
    logic             MemWrite;
    logic             IRWrite;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUOP;
    logic             illegal;
    logic             instr_done;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  Op, Zero,
        output PCEn, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, illegal, instr_done,
               state, instr_count
    );

    modport slave (
        output Op, Zero,
        input  PCEn, PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, illegal, instr_done,
               state, instr_count
    );
endinterface

// File: rtl/mc_control.sv
// Multi-cycle CPU main control FSM with retired-instruction counter.
// Latency: 2-5 cycles per instruction; control outputs are registered from the next state.
// No backpressure: FETCH follows every terminal state with no idle cycle.
`timescale 1ns/1ps
module mc_control #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    mc_control_if.master bus
);
    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  RWB    = 4'd7,
        BRANCH = 4'd8,  JUMP   = 4'd9,  IEXEC  = 4'd10, IWB    = 4'd11
    } state_t;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic [1:0] pcsource;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       done;
    } ctl_t;

    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.memread = 1'b1; c.irwrite = 1'b1; c.alusrcb = 2'b01;
                          c.aluop = 2'b01; c.pcwrite = 1'b1; end
            DECODE: begin c.alusrcb = 2'b11; c.aluop = 2'b01; end
            MEMADR: begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b01; end
            MEMRD:  begin c.memread = 1'b1; c.iord = 1'b1; end
            MEMWB:  begin c.regwrite = 1'b1; c.memtoreg = 1'b1; c.done = 1'b1; end
            MEMWR:  begin c.memwrite = 1'b1; c.iord = 1'b1; c.done = 1'b1; end
            EXEC:   begin c.alusrca = 1'b1; end
            RWB:    begin c.regwrite = 1'b1; c.regdst = 1'b1; c.done = 1'b1; end
            BRANCH: begin c.alusrca = 1'b1; c.aluop = 2'b10; c.pcwritecond = 1'b1;
                          c.pcsource = 2'b01; c.done = 1'b1; end
            JUMP:   begin c.pcwrite = 1'b1; c.pcsource = 2'b10; c.done = 1'b1; end
            IEXEC:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 2'b01; end
            IWB:    begin c.regwrite = 1'b1; c.done = 1'b1; end
            default: ;
        endcase
        return c;
    endfunction

    state_t           state_q;
    state_t           state_n;
    ctl_t             ctl_q;
    ctl_t             ctl_o;
    logic [CNT_W-1:0] cnt_q;
    logic             legal_op;
    logic             dec_illegal;
    logic             done;

    assign legal_op = (bus.Op == OP_R)   || (bus.Op == OP_LW)   || (bus.Op == OP_SW)   ||
                      (bus.Op == OP_BEQ) || (bus.Op == OP_J)    || (bus.Op == OP_ADDI) ||
                      (bus.Op == OP_ADDIU);

    always_comb begin
        state_n = FETCH;
        case (state_q)
            FETCH:  state_n = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW:      state_n = MEMADR;
                    OP_R:              state_n = EXEC;
                    OP_BEQ:            state_n = BRANCH;
                    OP_J:              state_n = JUMP;
                    OP_ADDI, OP_ADDIU: state_n = IEXEC;
                    default:           state_n = FETCH;
                endcase
            end
            MEMADR: state_n = (bus.Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_n = MEMWB;
            EXEC:   state_n = RWB;
            IEXEC:  state_n = IWB;
            default: state_n = FETCH;
        endcase
    end

    // Reset gates every strobe so nothing reaches the datapath while rst is high.
    assign ctl_o       = rst ? '0 : ctl_q;
    assign dec_illegal = !rst && (state_q == DECODE) && !legal_op;
    assign done        = ctl_o.done || dec_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            ctl_q   <= ctl_of(FETCH);
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            ctl_q   <= ctl_of(state_n);
            if (done) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.PCWrite     = ctl_o.pcwrite;
    assign bus.PCWriteCond = ctl_o.pcwritecond;
    assign bus.PCEn        = ctl_o.pcwrite | (ctl_o.pcwritecond & bus.Zero);
    assign bus.PCSource    = ctl_o.pcsource;
    assign bus.IorD        = ctl_o.iord;
    assign bus.MemRead     = ctl_o.memread;
    assign bus.MemWrite    = ctl_o.memwrite;
    assign bus.IRWrite     = ctl_o.irwrite;
    assign bus.MemtoReg    = ctl_o.memtoreg;
    assign bus.RegDst      = ctl_o.regdst;
    assign bus.RegWrite    = ctl_o.regwrite;
    assign bus.ALUSrcA     = ctl_o.alusrca;
    assign bus.ALUSrcB     = ctl_o.alusrcb;
    assign bus.ALUOP       = ctl_o.aluop;
    assign bus.illegal     = dec_illegal;
    assign bus.instr_done  = done;
    assign bus.state       = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mc_control.sv
// Scoreboarded bench for mc_control: instruction-level reference model feeds an expected queue,
// a negedge monitor pops one entry per cycle; a CNT_W=4 copy checks counter wrap.
`timescale 1ns/1ps
module tb_mc_control;
    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;

    always #5 clk = ~clk;

    mc_control_if #(.CNT_W(32)) bus ();
    mc_control_if #(.CNT_W(4))  bus4 ();

    assign bus.Op   = op;
    assign bus.Zero = zero;
    assign bus4.Op   = op;
    assign bus4.Zero = zero;

    mc_control #(.CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
    mc_control #(.CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    typedef struct {
        logic [3:0]  st;
        logic [18:0] outs;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc    = 0;
    logic [31:0] model_cnt = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    endtask

    // Which states an opcode walks through, from FETCH to its last cycle.
    function automatic int seq_state(input logic [5:0] o, input int k);
        int s[5];
        int n;
        s = '{0, 1, 0, 0, 0};
        n = 2;
        case (o)
            6'b000000:            begin s = '{0, 1, 6, 7, 0};  n = 4; end
            6'b100011:            begin s = '{0, 1, 2, 3, 4};  n = 5; end
            6'b101011:            begin s = '{0, 1, 2, 5, 0};  n = 4; end
            6'b000100:            begin s = '{0, 1, 8, 0, 0};  n = 3; end
            6'b000010:            begin s = '{0, 1, 9, 0, 0};  n = 3; end
            6'b001000, 6'b001001: begin s = '{0, 1, 10, 11, 0}; n = 4; end
            default: ;
        endcase
        return (k < n) ? s[k] : -1;
    endfunction

    function automatic int seq_len(input logic [5:0] o);
        int n = 0;
        while (seq_state(o, n) >= 0) n++;
        return n;
    endfunction

    // Output bundle in monitor order: PCEn..ALUOP, illegal, instr_done.
    function automatic logic [18:0] ref_outs(input int st, input logic z, input logic ill, input logic last);
        logic pcw = 0, pcwc = 0, iord = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rdst = 0, rw = 0, asa = 0;
        logic [1:0] pcs = 0, asb = 0, aop = 0;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 2'b01; aop = 2'b01; pcw = 1; end
            1:  begin asb = 2'b11; aop = 2'b01; end
            2:  begin asa = 1; asb = 2'b10; aop = 2'b01; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; end
            7:  begin rw = 1; rdst = 1; end
            8:  begin asa = 1; aop = 2'b10; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; aop = 2'b01; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {pcw | (pcwc & z), pcw, pcwc, pcs, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, ill, last};
    endfunction

    // Issue one instruction; abort_at >= 0 pulses rst during that cycle index.
    task automatic run_instr(input logic [5:0] o, input logic z, input int abort_at);
        int   n;
        exp_t e;
        logic legal;
        n     = seq_len(o);
        legal = (n > 2);
        op    = o;
        zero  = z;
        for (int k = 0; k < n; k++) begin
            if (abort_at >= 0 && k > abort_at) break;
            e.st   = 4'(seq_state(o, k));
            e.cnt  = model_cnt;
            e.outs = (k == abort_at) ? 19'd0
                   : ref_outs(seq_state(o, k), z, !legal && (k == 1), k == n - 1);
            sb.push_back(e);
        end
        for (int k = 0; k < n; k++) begin
            if (abort_at >= 0 && k > abort_at) break;
            if (k == abort_at) rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end
        if (abort_at >= 0) model_cnt = 0;
        else               model_cnt = model_cnt + 1;
    endtask

    initial begin : monitor
        exp_t e;
        logic [18:0] act;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {bus.PCEn, bus.PCWrite, bus.PCWriteCond, bus.PCSource, bus.IorD,
                       bus.MemRead, bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                       bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOP, bus.illegal,
                       bus.instr_done};
                chk("state", 32'(bus.state), 32'(e.st));
                chk("outputs", 32'(act), 32'(e.outs));
                chk("instr_count", bus.instr_count, e.cnt);
                chk("instr_count_w4", 32'(bus4.instr_count), 32'(e.cnt[3:0]));
            end
        end
    end

    initial begin : stimulus
        logic [5:0] ops[7];
        logic [5:0] o;
        int         ab;
        exp_t       e;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000, 6'b001001};
        rst  = 1'b1;
        op   = 6'b000000;
        zero = 1'b0;
        @(posedge clk);
        #1;
        e.st = 4'd0; e.outs = 19'd0; e.cnt = 32'd0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_cnt = 0;

        run_instr(6'b000000, 1'b0, -1);
        run_instr(6'b100011, 1'b0, -1);
        run_instr(6'b101011, 1'b1, -1);
        run_instr(6'b000100, 1'b1, -1);
        run_instr(6'b000100, 1'b0, -1);
        run_instr(6'b000010, 1'b0, -1);
        run_instr(6'b111111, 1'b1, -1);
        run_instr(6'b001000, 1'b0, -1);
        run_instr(6'b001001, 1'b1, -1);
        run_instr(6'b100011, 1'b0, 3);
        for (int i = 0; i < 17; i++) run_instr(6'b000000, 1'(i), -1);
        chk("wrap_w4_after_17", 32'(bus4.instr_count), 32'd1);

        for (int i = 0; i < 150; i++) begin
            o  = ($urandom_range(3) == 0) ? 6'($urandom) : ops[$urandom_range(6)];
            ab = ($urandom_range(11) == 0) ? int'($urandom_range(seq_len(o) - 1)) : -1;
            run_instr(o, 1'($urandom), ab);
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain: %0d expected entries left, required 0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
